// File: rtl/gpu_mma_if.sv
// Word-memory port of the matrix multiply-accumulate unit: one req/ack
// transfer per word, with request fields held stable until acknowledged.
interface gpu_mma_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/gpu_mma_unit.sv
// DIM x DIM tile matrix multiply-accumulate engine: loads A, B (and
// optionally C), computes one output row per cycle, then stores C.
module gpu_mma_unit #(
   parameter int DIM    = 4,
   parameter int ELEM_W = 8,
   parameter int OUT_W  = 16,
   parameter int ACC_W  = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        cfg_signed,
   input  logic        cfg_accum,
   input  logic        cfg_sat,
   input  logic [31:0] a_addr,
   input  logic [31:0] b_addr,
   input  logic [31:0] c_addr,
   output logic        busy,
   output logic        done,
   gpu_mma_if.master   mem
);

   localparam int EPW   = 32 / ELEM_W;
   localparam int WPR   = DIM / EPW;
   localparam int RPW   = 32 / OUT_W;
   localparam int CPR   = DIM / RPW;
   localparam int NA    = DIM * DIM / EPW;
   localparam int NC    = DIM * DIM / RPW;
   localparam int CNT_W = $clog2(NC);
   localparam int IDX_W = $clog2(DIM);

   localparam logic signed [ACC_W-1:0] SMAX = ACC_W'({(OUT_W-1){1'b1}});
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
   localparam logic        [ACC_W-1:0] UMAX = ACC_W'({OUT_W{1'b1}});

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_COMPUTE, S_STORE_C, S_DONE
   } state_t;

   state_t state, nxt;

   logic [CNT_W-1:0] wcnt;
   logic [IDX_W-1:0] rcnt;
   logic             sgn_q, acc_q, sat_q;
   logic [31:0]      a_base, b_base, c_base;

   logic [ELEM_W-1:0] a_mem [DIM][DIM];
   logic [ELEM_W-1:0] b_mem [DIM][DIM];
   logic [ACC_W-1:0]  acc   [DIM][DIM];
   logic [ACC_W-1:0]  row_sum [DIM];
   logic [31:0]       wdata_w;

   logic             xfer, last_word, last_row;
   logic [IDX_W-1:0] ld_row, ld_col, c_row, c_col;
   logic [31:0]      offs;

   function automatic logic [ACC_W-1:0] mul(input logic [ELEM_W-1:0] a,
                                            input logic [ELEM_W-1:0] b,
                                            input logic sgn);
      logic signed [ELEM_W-1:0] sa, sb;
      logic signed [ACC_W-1:0]  ea, eb;
      sa = a;
      sb = b;
      if (sgn) begin
         ea = ACC_W'(sa);
         eb = ACC_W'(sb);
      end else begin
         ea = ACC_W'(a);
         eb = ACC_W'(b);
      end
      return ea * eb;
   endfunction

   function automatic logic [ACC_W-1:0] ext_c(input logic [OUT_W-1:0] v,
                                              input logic sgn);
      logic signed [OUT_W-1:0] sv;
      sv = v;
      if (sgn) return ACC_W'(sv);
      else     return ACC_W'(v);
   endfunction

   function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] v,
                                                input logic sgn,
                                                input logic sat);
      logic signed [ACC_W-1:0] sv;
      logic [OUT_W-1:0]        r;
      sv = v;
      r  = v[OUT_W-1:0];
      if (OUT_W < ACC_W && sat) begin
         if (sgn) begin
            if (sv > SMAX)      r = SMAX[OUT_W-1:0];
            else if (sv < SMIN) r = SMIN[OUT_W-1:0];
         end else if (v > UMAX) begin
            r = UMAX[OUT_W-1:0];
         end
      end
      return r;
   endfunction

   // An ack coinciding with abort is dropped entirely.
   assign xfer     = mem.mem_req && mem.mem_ack && !abort;
   assign last_row = (rcnt == IDX_W'(DIM - 1));
   assign ld_row   = IDX_W'(int'(wcnt) / WPR);
   assign ld_col   = IDX_W'((int'(wcnt) % WPR) * EPW);
   assign c_row    = IDX_W'(int'(wcnt) / CPR);
   assign c_col    = IDX_W'((int'(wcnt) % CPR) * RPW);
   assign offs     = 32'(wcnt) << 2;

   always_comb begin
      last_word = 1'b0;
      case (state)
         S_LOAD_A, S_LOAD_B:  last_word = (wcnt == CNT_W'(NA - 1));
         S_LOAD_C, S_STORE_C: last_word = (wcnt == CNT_W'(NC - 1));
         default:             last_word = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (abort) begin
         nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (start) nxt = S_LOAD_A;
            S_LOAD_A:  if (xfer && last_word) nxt = S_LOAD_B;
            S_LOAD_B:  if (xfer && last_word) nxt = acc_q ? S_LOAD_C : S_COMPUTE;
            S_LOAD_C:  if (xfer && last_word) nxt = S_COMPUTE;
            S_COMPUTE: if (last_row) nxt = S_STORE_C;
            S_STORE_C: if (xfer && last_word) nxt = S_DONE;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state)
         S_LOAD_A: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = a_base + offs;
         end
         S_LOAD_B: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = b_base + offs;
         end
         S_LOAD_C: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = c_base + offs;
         end
         S_STORE_C: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = c_base + offs;
            mem.mem_wdata = wdata_w;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= '0;
         rcnt <= '0;
      end else if (abort) begin
         wcnt <= '0;
         rcnt <= '0;
      end else begin
         if (xfer) wcnt <= last_word ? '0 : wcnt + 1'b1;
         if (state == S_COMPUTE) rcnt <= last_row ? '0 : rcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && start && !abort) begin
         sgn_q  <= cfg_signed;
         acc_q  <= cfg_accum;
         sat_q  <= cfg_sat;
         a_base <= a_addr;
         b_base <= b_addr;
         c_base <= c_addr;
      end
   end

   // Operand capture, accumulator preload/clear and one output row per cycle.
   always_comb begin
      for (int j = 0; j < DIM; j++) begin
         row_sum[j] = '0;
         for (int k = 0; k < DIM; k++)
            row_sum[j] = row_sum[j] + mul(a_mem[rcnt][k], b_mem[k][j], sgn_q);
      end
   end

   always_ff @(posedge clk) begin
      if (xfer && state == S_LOAD_A)
         for (int e = 0; e < EPW; e++)
            a_mem[ld_row][ld_col + IDX_W'(e)] <= mem.mem_rdata[e*ELEM_W +: ELEM_W];
      if (xfer && state == S_LOAD_B)
         for (int e = 0; e < EPW; e++)
            b_mem[ld_row][ld_col + IDX_W'(e)] <= mem.mem_rdata[e*ELEM_W +: ELEM_W];
      if (xfer && state == S_LOAD_C)
         for (int e = 0; e < RPW; e++)
            acc[c_row][c_col + IDX_W'(e)] <= ext_c(mem.mem_rdata[e*OUT_W +: OUT_W], sgn_q);
      if (xfer && state == S_LOAD_B && last_word && !acc_q)
         for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++)
               acc[r][j] <= '0;
      if (state == S_COMPUTE)
         for (int j = 0; j < DIM; j++)
            acc[rcnt][j] <= acc[rcnt][j] + row_sum[j];
   end

   always_comb begin
      wdata_w = '0;
      for (int e = 0; e < RPW; e++)
         wdata_w[e*OUT_W +: OUT_W] = sat_out(acc[c_row][c_col + IDX_W'(e)], sgn_q, sat_q);
   end

endmodule

// File: tb/tb_gpu_mma_unit.sv
// Self-checking bench for gpu_mma_unit: table vectors, randomized runs with
// ack gaps against an arithmetic model, abort and reset sequences.
module tb_gpu_mma_unit;
   localparam int DIM = 4, ELEM_W = 8, OUT_W = 16, ACC_W = 32;
   localparam int NC = 8;
   localparam logic [31:0] A_BASE = 32'h40, B_BASE = 32'h80, C_BASE = 32'hC0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0;
   logic cfg_signed = 1'b0, cfg_accum = 1'b0, cfg_sat = 1'b0;
   logic [31:0] a_addr = A_BASE, b_addr = B_BASE, c_addr = C_BASE;
   logic busy, done;

   gpu_mma_if mem ();

   gpu_mma_unit #(.DIM(DIM), .ELEM_W(ELEM_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_signed(cfg_signed), .cfg_accum(cfg_accum), .cfg_sat(cfg_sat),
      .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
      .busy(busy), .done(done), .mem(mem)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Memory responder: reads from rd_img, records stores in wr_img.
   logic [31:0] rd_img [64];
   logic [31:0] wr_img [64];
   logic        ack_r = 1'b0;
   logic [31:0] rdata_r = '0;
   int max_gap = 0, gap = 0, c_reads = 0, wr_cnt = 0, done_cnt = 0, unstable = 0;
   logic        prev_pend = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;

   assign mem.mem_ack   = ack_r;
   assign mem.mem_rdata = rdata_r;

   always @(negedge clk) begin
      if (mem.mem_req && prev_pend &&
          (mem.mem_addr != prev_addr || mem.mem_wdata != prev_wdata))
         unstable++;
      ack_r = 1'b0;
      if (mem.mem_req && rst_n) begin
         if (gap == 0) begin
            ack_r   = 1'b1;
            rdata_r = rd_img[mem.mem_addr[7:2]];
            if (mem.mem_we) begin
               wr_img[mem.mem_addr[7:2]] = mem.mem_wdata;
               wr_cnt++;
            end else if (mem.mem_addr >= C_BASE && mem.mem_addr < C_BASE + 32) begin
               c_reads++;
            end
            gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
         end else begin
            gap--;
         end
      end
      prev_pend  = mem.mem_req && !ack_r;
      prev_addr  = mem.mem_addr;
      prev_wdata = mem.mem_wdata;
      if (done) done_cnt++;
   end

   // Matrices (raw bit patterns) and the expected store image.
   int am [4][4];
   int bm [4][4];
   int cm [4][4];
   logic [31:0] exp_w [NC];

   function automatic longint elem(input int raw, input int w, input bit sgn);
      longint v;
      v = longint'(raw) & ((64'sd1 <<< w) - 1);
      if (sgn && v >= (64'sd1 <<< (w - 1))) v -= (64'sd1 <<< w);
      return v;
   endfunction

   task automatic model(input bit sgn, input bit accum, input bit sat);
      longint s;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            s = accum ? elem(cm[r][c], 16, sgn) : 64'sd0;
            for (int k = 0; k < 4; k++) s += elem(am[r][k], 8, sgn) * elem(bm[k][c], 8, sgn);
            s = s & 64'sh0000_0000_FFFF_FFFF;
            if (sgn && s >= 64'sh8000_0000) s -= 64'sh1_0000_0000;
            if (sat) begin
               if (sgn && s > 32767) s = 32767;
               else if (sgn && s < -32768) s = -32768;
               else if (!sgn && s > 65535) s = 65535;
            end
            exp_w[(r*4 + c) / 2][((r*4 + c) % 2)*16 +: 16] = s[15:0];
         end
   endtask

   task automatic load_image();
      for (int r = 0; r < 4; r++) begin
         rd_img[16 + r] = {am[r][3][7:0], am[r][2][7:0], am[r][1][7:0], am[r][0][7:0]};
         rd_img[32 + r] = {bm[r][3][7:0], bm[r][2][7:0], bm[r][1][7:0], bm[r][0][7:0]};
         rd_img[48 + 2*r]     = {cm[r][1][15:0], cm[r][0][15:0]};
         rd_img[48 + 2*r + 1] = {cm[r][3][15:0], cm[r][2][15:0]};
      end
   endtask

   function automatic int pat(input int p, input int i, input int j);
      case (p)
         0:       return (i == j) ? 1 : 0;
         1:       return 32'h80;
         2:       return 4*i + j;
         3:       return 32'h7F;
         default: return int'($urandom);
      endcase
   endfunction

   task automatic set_mats(input int ap, input int bp, input int cin);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            am[i][j] = pat(ap, i, j);
            bm[i][j] = pat(bp, i, j);
            cm[i][j] = (cin < 0) ? int'($urandom) : cin;
         end
      load_image();
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      @(negedge clk);
      while (busy && g < 200) begin @(negedge clk); g++; end
   endtask

   // One operation; extra_at > 0 pulses start again that many cycles in.
   task automatic run_op(input bit sgn, input bit acc, input bit sat,
                         input int extra_at, output int lat);
      wait_idle();
      cfg_signed = sgn; cfg_accum = acc; cfg_sat = sat;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_signed = ~sgn; cfg_accum = ~acc; cfg_sat = ~sat;
      lat = 1;
      while (!done && lat < 3000) begin
         @(posedge clk); #1;
         lat++;
         start = (lat == extra_at);
      end
      start = 1'b0;
      if (!done) $display("FAIL op_timeout: got no done after %0d cycles, expected done", lat);
      if (!done) n_total++;
   endtask

   task automatic check_store(input string name);
      for (int w = 0; w < NC; w++)
         check($sformatf("%s_w%0d", name, w), longint'(wr_img[48 + w]), longint'(exp_w[w]));
   endtask

   typedef struct {
      bit sgn, acc, sat;
      int a_pat, b_pat, cin;
      logic [31:0] exp_w0;
      int exp_lat, exp_creads;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int lat, base_done, base_c, base_wr, g;
      bit found;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 2, 0, 32'h0001_0000, 21, 0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 1, 3, 0, 32'h8000_8000, 21, 0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 32'h0200_0200, 21, 0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 0, 0, 5, 32'h0005_0006, 29, 8};

      for (int i = 0; i < 64; i++) begin rd_img[i] = '0; wr_img[i] = '0; end

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {busy, done, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_idle", {busy, done, mem.mem_req}, 0);

      // Table-driven vectors, ack every cycle.
      for (int v = 0; v < 4; v++) begin
         max_gap = 0;
         set_mats(vecs[v].a_pat, vecs[v].b_pat, vecs[v].cin);
         model(vecs[v].sgn, vecs[v].acc, vecs[v].sat);
         base_done = done_cnt; base_c = c_reads; base_wr = wr_cnt;
         run_op(vecs[v].sgn, vecs[v].acc, vecs[v].sat, 0, lat);
         repeat (3) @(negedge clk);
         check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
         check($sformatf("vec%0d_word0", v), wr_img[48], vecs[v].exp_w0);
         check_store($sformatf("vec%0d", v));
         check($sformatf("vec%0d_c_reads", v), c_reads - base_c, vecs[v].exp_creads);
         check($sformatf("vec%0d_writes", v), wr_cnt - base_wr, NC);
         check($sformatf("vec%0d_done_pulses", v), done_cnt - base_done, 1);
      end

      // Randomized runs with ack gaps against the model.
      max_gap = 5;
      for (int t = 0; t < 6; t++) begin
         bit s, a, z;
         s = 1'($urandom); a = 1'($urandom); z = 1'($urandom);
         set_mats(4, 4, -1);
         model(s, a, z);
         base_wr = wr_cnt;
         run_op(s, a, z, 0, lat);
         check_store($sformatf("rand%0d", t));
         check($sformatf("rand%0d_writes", t), wr_cnt - base_wr, NC);
      end
      check("req_fields_stable", unstable, 0);

      // Abort on the third B word with an ack in the same cycle.
      max_gap = 0;
      set_mats(4, 4, -1);
      wait_idle();
      cfg_signed = 1'b0; cfg_accum = 1'b0; cfg_sat = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0; g = 0;
      while (!found && g < 100) begin
         @(negedge clk);
         g++;
         if (mem.mem_req && !mem.mem_we && mem.mem_addr == B_BASE + 8) begin
            found = 1'b1;
            abort = 1'b1;
         end
      end
      check("abort_reached_b2", found, 1);
      check("abort_ack_same_cycle", ack_r, 1);
      base_done = done_cnt;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_idle", {busy, mem.mem_req}, 0);
      repeat (25) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - base_done, 0);

      // abort in IDLE wins over start.
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("abort_beats_start", busy, 0);

      set_mats(4, 4, -1);
      model(1'b1, 1'b0, 1'b1);
      run_op(1'b1, 1'b0, 1'b1, 0, lat);
      check_store("after_abort");

      // Reset asserted mid-STORE_C.
      set_mats(4, 4, -1);
      wait_idle();
      cfg_signed = 1'b0; cfg_accum = 1'b0; cfg_sat = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      g = 0;
      while (!mem.mem_we && g < 100) begin @(negedge clk); g++; end
      check("reached_store", mem.mem_we, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {busy, done, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata}, 0);
      base_wr = wr_cnt;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_no_req", {busy, mem.mem_req}, 0);
      @(negedge clk) rst_n = 1'b1;
      check("reset_no_writes", wr_cnt - base_wr, 0);

      // start while busy is ignored: one done, normal latency.
      max_gap = 0;
      set_mats(4, 4, -1);
      model(1'b0, 1'b0, 1'b0);
      base_done = done_cnt;
      run_op(1'b0, 1'b0, 1'b0, 6, lat);
      repeat (30) @(negedge clk);
      check("busy_start_latency", lat, 21);
      check("busy_start_single_done", done_cnt - base_done, 1);
      check("busy_start_idle_after", busy, 0);
      check_store("busy_start");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got simulation still running, expected finish");
      $fatal(1);
   end
endmodule
